// File: rtl/rooth_inst_loader.sv
// rooth_inst_loader
//   In-system boot loader for the rooth core. Accepts a byte stream
//   (4-byte little-endian word count L, 4*L little-endian data bytes,
//   1 XOR checksum byte over the data bytes), writes the assembled words
//   to instruction memory from word address 0, and holds the core in
//   reset until a load completes with a matching checksum.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   start_i        single-cycle pulse that begins a load
//   rx_data_i      incoming byte
//   rx_valid_i     rx_data_i valid
//   rx_ready_o     loader accepts a byte this cycle
//   mem_we_o       instruction memory write strobe (one cycle per word)
//   mem_addr_o     word address
//   mem_wdata_o    word to write
//   core_rst_n_o   active-low reset to the rooth core
//   busy_o         load in progress
//   done_o         last load completed with good checksum
//   err_o          last load failed (bad length or bad checksum)
//   words_o        words written by the current or last load
//
// State table
//   IDLE  | waiting for start_i after reset
//   LEN   | collecting the 4 length bytes
//   DATA  | collecting the 4 bytes of the next word
//   WRITE | one-cycle memory write of the assembled word
//   SUM   | waiting for the checksum byte
//   DONE  | good load, core released
//   ERR   | failed load, core held in reset
module rooth_inst_loader #(
   parameter int ADDR_W    = 12,
   parameter int CPU_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [CPU_WIDTH-1:0] mem_wdata_o,
   output logic                 core_rst_n_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ADDR_W:0]      words_o
);

   typedef enum logic [2:0] {
      IDLE, LEN, DATA, WRITE, SUM, DONE, ERR
   } state_t;

   localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

   state_t                r_state;
   logic                  r_rx_ready;
   logic                  r_mem_we;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [CPU_WIDTH-1:0]  r_mem_wdata;
   logic                  r_core_rst_n;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic [ADDR_W:0]       r_words;
   logic [ADDR_W:0]       r_len;
   logic [23:0]           r_shift;
   logic [1:0]            r_byte_cnt;
   logic [7:0]            r_xor;

   logic                  w_xfer;
   logic [31:0]           w_full;
   logic [ADDR_W:0]       w_words_inc;

   assign w_xfer      = rx_valid_i & r_rx_ready;
   // Bytes arrive LSB first and shift down, so the 4th byte completes the
   // little-endian value combinationally without being stored.
   assign w_full      = {rx_data_i, r_shift};
   assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rx_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_core_rst_n <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_words      <= '0;
         r_len        <= '0;
         r_shift      <= '0;
         r_byte_cnt   <= '0;
         r_xor        <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  r_state      <= LEN;
                  r_rx_ready   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_core_rst_n <= 1'b0;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_words      <= '0;
                  r_shift      <= '0;
                  r_byte_cnt   <= '0;
                  r_xor        <= '0;
               end
            end
            LEN: begin
               if (w_xfer) begin
                  r_shift    <= w_full[31:8];
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     if (w_full == 32'd0 || w_full > MAX_LEN) begin
                        r_state    <= ERR;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                     end else begin
                        r_state <= DATA;
                        r_len   <= w_full[ADDR_W:0];
                     end
                  end
               end
            end
            DATA: begin
               if (w_xfer) begin
                  r_shift    <= w_full[31:8];
                  r_xor      <= r_xor ^ rx_data_i;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_state     <= WRITE;
                     r_rx_ready  <= 1'b0;
                     r_mem_we    <= 1'b1;
                     // Address equals the count of words already written.
                     r_mem_addr  <= r_words[ADDR_W-1:0];
                     r_mem_wdata <= CPU_WIDTH'(w_full);
                  end
               end
            end
            WRITE: begin
               r_words    <= w_words_inc;
               r_rx_ready <= 1'b1;
               r_state    <= (w_words_inc == r_len) ? SUM : DATA;
            end
            SUM: begin
               if (w_xfer) begin
                  r_rx_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  if (rx_data_i == r_xor) begin
                     r_state      <= DONE;
                     r_done       <= 1'b1;
                     r_core_rst_n <= 1'b1;
                  end else begin
                     r_state <= ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_ready_o   = r_rx_ready;
   assign mem_we_o     = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_wdata_o  = r_mem_wdata;
   assign core_rst_n_o = r_core_rst_n;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign words_o      = r_words;

endmodule

// File: tb/tb_rooth_inst_loader.sv
// tb_rooth_inst_loader
//   Bench for rooth_inst_loader. Expected memory writes are queued as
//   each word's bytes are driven and popped by a monitor on every
//   mem_we_o cycle; status outputs are checked after each load.
module tb_rooth_inst_loader;

   localparam int ADDR_W    = 12;
   localparam int CPU_WIDTH = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start_i;
   logic [7:0]           rx_data_i;
   logic                 rx_valid_i;
   logic                 rx_ready_o;
   logic                 mem_we_o;
   logic [ADDR_W-1:0]    mem_addr_o;
   logic [CPU_WIDTH-1:0] mem_wdata_o;
   logic                 core_rst_n_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 err_o;
   logic [ADDR_W:0]      words_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_we    = 0;
   logic [63:0] sb[$];
   logic [31:0] good_q[$];
   logic [31:0] full_q[$];

   rooth_inst_loader #(.ADDR_W(ADDR_W), .CPU_WIDTH(CPU_WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .rx_data_i    (rx_data_i),
      .rx_valid_i   (rx_valid_i),
      .rx_ready_o   (rx_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .core_rst_n_o (core_rst_n_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .words_o      (words_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we_o === 1'b1) begin
         n_we++;
         if (sb.size() == 0)
            check_val("we_with_nothing_expected", {63'd0, mem_we_o}, 64'd0);
         else
            check_val("mem_write", {20'd0, mem_addr_o, mem_wdata_o}, sb.pop_front());
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit bubble);
      bit acc;
      acc = 1'b0;
      if (bubble) begin
         rx_valid_i = 1'b0;
         @(posedge clk); #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = rx_ready_o;
         @(posedge clk); #1;
         if (acc) break;
      end
      if (!acc) check_val("rx_accept_timeout", {63'd0, acc}, 64'd1);
      rx_valid_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] len, input bit bubble);
      for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], bubble);
   endtask

   task automatic send_words(input logic [31:0] wq[$], input bit bad_sum,
                             input bit bubble, input bit mid_start);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      for (int i = 0; i < wq.size(); i++) begin
         for (int k = 0; k < 4; k++) begin
            b = wq[i][8*k +: 8];
            x = x ^ b;
            send_byte(b, bubble);
            if (mid_start && i == 0 && k == 1) pulse_start();
         end
         sb.push_back((64'(i) << 32) | 64'(wq[i]));
      end
      send_byte(bad_sum ? (x ^ 8'h01) : x, bubble);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string t, input logic d, input logic e,
                               input logic core, input logic [ADDR_W:0] w);
      check_val({t, "_done"}, {63'd0, done_o}, {63'd0, d});
      check_val({t, "_err"}, {63'd0, err_o}, {63'd0, e});
      check_val({t, "_core_rst_n"}, {63'd0, core_rst_n_o}, {63'd0, core});
      check_val({t, "_words"}, 64'(words_o), 64'(w));
      check_val({t, "_busy"}, {63'd0, busy_o}, 64'd0);
      check_val({t, "_sb_drained"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      rst        = 1'b1;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      good_q.push_back(32'h0000_0093);
      good_q.push_back(32'h0010_0113);
      for (int i = 0; i < 4096; i++) full_q.push_back(32'(i));

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_rx_ready", {63'd0, rx_ready_o}, 64'd0);
      check_val("rst_mem_we", {63'd0, mem_we_o}, 64'd0);
      check_val("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      check_val("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
      check_val("rst_core_rst_n", {63'd0, core_rst_n_o}, 64'd0);
      check_val("rst_busy", {63'd0, busy_o}, 64'd0);
      check_val("rst_done", {63'd0, done_o}, 64'd0);
      check_val("rst_err", {63'd0, err_o}, 64'd0);
      check_val("rst_words", 64'(words_o), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // good load
      we0 = n_we;
      pulse_start();
      check_val("good_busy_after_start", {63'd0, busy_o}, 64'd1);
      check_val("good_ready_in_len", {63'd0, rx_ready_o}, 64'd1);
      send_len(32'd2, 1'b0);
      send_words(good_q, 1'b0, 1'b0, 1'b0);
      check_status("good", 1'b1, 1'b0, 1'b1, 13'd2);
      check_val("good_we_count", 64'(n_we - we0), 64'd2);

      // bad checksum, then recovery
      pulse_start();
      check_val("restart_core_held", {63'd0, core_rst_n_o}, 64'd0);
      send_len(32'd2, 1'b0);
      send_words(good_q, 1'b1, 1'b0, 1'b0);
      check_status("badsum", 1'b0, 1'b1, 1'b0, 13'd2);
      pulse_start();
      send_len(32'd2, 1'b0);
      send_words(good_q, 1'b0, 1'b0, 1'b0);
      check_status("recover", 1'b1, 1'b0, 1'b1, 13'd2);

      // length errors
      we0 = n_we;
      pulse_start();
      send_len(32'd0, 1'b0);
      check_val("len0_err", {63'd0, err_o}, 64'd1);
      check_val("len0_ready", {63'd0, rx_ready_o}, 64'd0);
      check_val("len0_core_rst_n", {63'd0, core_rst_n_o}, 64'd0);
      pulse_start();
      send_len(32'h0000_1001, 1'b0);
      check_val("len4097_err", {63'd0, err_o}, 64'd1);
      check_val("len4097_done", {63'd0, done_o}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check_val("lenerr_no_we", 64'(n_we - we0), 64'd0);
      check_val("lenerr_words", 64'(words_o), 64'd0);

      // bubbles on every byte, bytes held across WRITE, start mid-DATA
      we0 = n_we;
      pulse_start();
      send_len(32'd2, 1'b1);
      send_words(good_q, 1'b0, 1'b1, 1'b1);
      check_status("bubble", 1'b1, 1'b0, 1'b1, 13'd2);
      check_val("bubble_we_count", 64'(n_we - we0), 64'd2);

      // asynchronous reset mid-load
      pulse_start();
      send_len(32'd2, 1'b0);
      send_byte(8'h93, 1'b0);
      send_byte(8'h00, 1'b0);
      check_val("prerst_busy", {63'd0, busy_o}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_val("midrst_busy", {63'd0, busy_o}, 64'd0);
      check_val("midrst_ready", {63'd0, rx_ready_o}, 64'd0);
      check_val("midrst_mem_addr", 64'(mem_addr_o), 64'd0);
      check_val("midrst_mem_wdata", 64'(mem_wdata_o), 64'd0);
      check_val("midrst_words", 64'(words_o), 64'd0);
      #10;
      rst = 1'b0;
      @(posedge clk); #1;
      pulse_start();
      send_len(32'd2, 1'b0);
      send_words(good_q, 1'b0, 1'b0, 1'b0);
      check_status("after_rst", 1'b1, 1'b0, 1'b1, 13'd2);

      // full capacity
      we0 = n_we;
      pulse_start();
      send_len(32'd4096, 1'b0);
      send_words(full_q, 1'b0, 1'b0, 1'b0);
      check_status("full", 1'b1, 1'b0, 1'b1, 13'd4096);
      check_val("full_we_count", 64'(n_we - we0), 64'd4096);
      check_val("full_last_addr", 64'(mem_addr_o), 64'hFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rooth_inst_loader.md
Name: rooth_inst_loader

Overview:
- Synthesizable boot loader. Receives a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory from word address 0.
- Holds the rooth core in reset for the whole load. Releases the core only after a successful checksum.
- The in-system counterpart of the simulation-only instruction-memory preload.
- Sits in rooth_soc between the byte source (UART RX or debug port) and the inst_mem write port.

Parameters:
- ADDR_W, 12, instruction memory word-address width; capacity is 2**ADDR_W words.
- CPU_WIDTH, 32, instruction word width. Fixed at 32; the 4-bytes-per-word assembly depends on it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  single-cycle pulse that begins a load
- rx_data_i  in  8  incoming byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  loader accepts a byte this cycle
- mem_we_o  out  1  instruction memory write strobe
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  CPU_WIDTH  word to write
- core_rst_n_o  out  1  active-low reset to the rooth core
- busy_o  out  1  load in progress
- done_o  out  1  last load completed with good checksum
- err_o  out  1  last load failed
- words_o  out  ADDR_W+1  number of words written by the current or last load

Behaviour:
- Reset values: rx_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_n_o=0, busy_o=0, done_o=0, err_o=0, words_o=0. State is IDLE.
- A byte is transferred only when rx_valid_i && rx_ready_o. rx_ready_o is a registered function of state: 1 in LEN, DATA and SUM; 0 in all other states.
- Stream format: 4-byte length L (words, little-endian), then 4*L data bytes (each word little-endian), then 1 checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.
- FSM states:
  - IDLE: on start_i go to LEN. Clear words_o, the address counter, the byte counter and the running XOR. Clear done_o and err_o. Set busy_o=1 and core_rst_n_o=0.
  - LEN: collect 4 bytes into L. After the 4th byte:
    - L==0 or L>2**ADDR_W -> ERR.
    - Otherwise -> DATA.
  - DATA: shift bytes into the word register (byte k goes to bits 8k+7:8k) and fold each byte into the XOR. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle with mem_we_o=1, mem_addr_o=current address and mem_wdata_o=assembled word. The word is written the cycle after its 4th byte is accepted. Then increment address and words_o. If words_o (after increment) == L -> SUM, else -> DATA. No byte is accepted in WRITE.
  - SUM: accept 1 byte. If it equals the XOR -> DONE, else -> ERR.
  - DONE: done_o=1, busy_o=0, core_rst_n_o=1. Stay here until start_i, then behave as IDLE+start.
  - ERR: err_o=1, busy_o=0, core_rst_n_o=0. Words already written are not undone. Stay here until start_i, then behave as IDLE+start.
- start_i in LEN, DATA, WRITE or SUM is ignored.
- mem_we_o is never asserted outside WRITE. mem_addr_o never exceeds 2**ADDR_W-1; the length check guarantees this with no wrap.
- Bubbles are tolerated: rx_valid_i may drop at any point with no timeout. A byte offered during a not-ready cycle is held by the source and accepted later, never lost.
- Asserting rst mid-load: all outputs return to reset values immediately (asynchronously) and partial words are discarded. The next start_i reloads from address 0.
- core_rst_n_o is registered and glitch-free. It rises only on the DONE entry edge.

Test Plan:
- Good load: start_i, then bytes 02 00 00 00 93 00 00 00 13 01 10 00 91 -> mem writes addr0=0x00000093 and addr1=0x00100113, one mem_we_o cycle each. Then done_o=1, err_o=0, words_o=2, core_rst_n_o=1.
- Bad checksum: same stream with last byte 90 -> both words written, err_o=1, done_o=0, core_rst_n_o=0. A following start_i plus the good stream -> done_o=1.
- Length errors: length 00 00 00 00 -> err_o=1 right after the 4th header byte, no mem_we_o. Length 01 10 00 00 (4097, ADDR_W=12) -> err_o=1, no mem_we_o.
- Flow control: good-load stream with rx_valid_i toggled 1/0 each cycle, and a byte presented during a WRITE cycle -> the byte is held until rx_ready_o and identical memory contents result. start_i mid-DATA is ignored.
- Reset mid-load: rst asserted after 2 data bytes -> outputs take reset values in the same cycle without waiting for a clock edge. Rerun of the good load -> addr0=0x00000093, done_o=1.
- Full capacity: L=4096 with word i = i -> last write at addr 0xFFF, words_o=4096, done_o=1, no address wrap.
